mem_pattern_tester: RTL
=======================

// Module: mem_pattern_tester
// PURPOSE
//  Parametrised successor to the fixed SDRAM random tester: endless write-all/read-all/compare passes over a
//  programmable span through a generic valid/ready memory port, so any controller (SDRAM, SRAM, BRAM) can sit
//  behind it. Adds selectable data patterns, pipelined reads with bounded outstanding count, first-error capture
//  and saturating counters. Sits between top-level status/OSD logic and the memory controller under test.
// PARAMETERS
//  DW          16        data width (>=8, even)
//  AW          24        word address width
//  MAX_OUTST   8         max read requests in flight (2..255)
//  INIT_CYCLES 5000000   idle cycles after reset before first pass (lets controller init / drain stale reads)
//  SEED        32'hACE1  initial 32-bit Galois LFSR state (must be nonzero)
// PORTS
//  clk            in   1   clock
//  rst            in   1   synchronous reset, active-high
//  mode           in   2   0=LFSR random, 1=address-as-data, 2=walking one, 3=checkerboard; sampled at pass start
//  addr_last      in   AW  last word address tested (span 0..addr_last); sampled at pass start
//  req_valid      out  1   memory request valid
//  req_ready      in   1   memory accepts request when req_valid&req_ready
//  req_we         out  1   1=write, 0=read
//  req_addr       out  AW  word address
//  req_wdata      out  DW  write data
//  rd_valid       in   1   read data valid, responses strictly in request order
//  rd_data        in   DW  read data
//  busy           out  1   1 in WRITE/READ/DRAIN
//  passcount      out  32  completed passes, saturating
//  failcount      out  32  mismatching words, saturating
//  err_flag       out  1   sticky: at least one mismatch since reset
//  first_err_addr out  AW  address of first mismatch
//  first_err_exp  out  DW  expected data of first mismatch
//  first_err_act  out  DW  read data of first mismatch
// BEHAVIOUR
//  Reset: all outputs 0, state INIT, init counter 0, pass seed=SEED; takes effect next edge, also mid-pass
//   (req_valid drops immediately, outstanding counter cleared).
//  FSM: INIT -(INIT_CYCLES elapsed)-> WRITE -(write to addr_last accepted)-> READ -(read of addr_last accepted)->
//   DRAIN -(outstanding==0)-> DONE (1 cycle: passcount+1, pass seed<=LFSR state after write phase) -> WRITE.
//  WRITE entry latches mode, addr_last, pass parity p=passcount[0]; address counter from 0, step on accept.
//  Request fields stay stable while req_valid&!req_ready. req_valid continuous in WRITE/READ (no bubbles
//   unless stalled); READ deasserts req_valid while outstanding==MAX_OUTST.
//  outstanding: +1 on read accept, -1 on rd_valid, unchanged when both same cycle.
//  Pattern d(a): mode0 = lfsr[DW-1:0], LFSR advances per word; mode1 = a[DW-1:0]^{DW{p}};
//   mode2 = 1<<((a+passcount) mod DW); mode3 = (a[0]^p) ? {DW/2{2'b10}} : {DW/2{2'b01}}.
//  Compare side: own address counter and own LFSR copy restored to pass seed at READ entry, both stepped
//   per rd_valid; expected = d(compare address). No data FIFO.
//  Mismatch on rd_valid in READ/DRAIN: failcount+1 (hold at 32'hFFFF_FFFF); if err_flag==0 capture addr/exp/act
//   and set err_flag same edge. Captures and err_flag clear only on rst.
//  rd_valid in INIT/WRITE/DONE ignored. addr_last==0: one-word pass, legal. Passes run forever.
// TESTING
//  Ideal memory model, latency 3, req_ready=1, INIT_CYCLES=10, AW=8, DW=16, MAX_OUTST=4:
//  1 mode0, addr_last=15 -> 16 writes then 16 reads, passcount=1 at DONE, failcount=0, err_flag=0.
//  2 mode1 pass0, flip rd_data bit0 at addr 5 -> failcount=1, first_err_addr=5, exp=16'h0005, act=16'h0004.
//  3 req_ready random 50%, latency 7 -> fields stable while stalled, outstanding never >4, failcount=0.
//  4 mode3 -> pass0 writes addr0=16'h5555, addr1=16'hAAAA; pass1 addr0=16'hAAAA.
//  5 rst high one cycle mid-READ -> next cycle req_valid=0, counters/err 0, busy=0; WRITE restarts after 10 cycles.
//  6 force passcount=32'hFFFF_FFFE, run 2 passes -> passcount holds 32'hFFFF_FFFF.

Source files
------------

// File: rtl/mem_pattern_tester.sv
// Memory pattern tester: repeated write-all / read-all / compare passes over
// words 0..addr_last through a generic valid/ready request port. Reads are
// pipelined with a bounded number in flight; responses are checked in order
// against a regenerated expected pattern (no data FIFO).
module mem_pattern_tester #(
   parameter int unsigned DW          = 16,
   parameter int unsigned AW          = 24,
   parameter int unsigned MAX_OUTST   = 8,
   parameter int unsigned INIT_CYCLES = 5000000,
   parameter logic [31:0] SEED        = 32'hACE1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [1:0]    mode,
   input  logic [AW-1:0] addr_last,
   output logic          req_valid,
   input  logic          req_ready,
   output logic          req_we,
   output logic [AW-1:0] req_addr,
   output logic [DW-1:0] req_wdata,
   input  logic          rd_valid,
   input  logic [DW-1:0] rd_data,
   output logic          busy,
   output logic [31:0]   passcount,
   output logic [31:0]   failcount,
   output logic          err_flag,
   output logic [AW-1:0] first_err_addr,
   output logic [DW-1:0] first_err_exp,
   output logic [DW-1:0] first_err_act
);

   localparam int unsigned OW  = $clog2(MAX_OUTST + 1);
   localparam int unsigned ICW = (INIT_CYCLES > 1) ? $clog2(INIT_CYCLES) : 1;
   localparam int unsigned SW  = ((AW > 32) ? AW : 32) + 1;

   localparam logic [ICW-1:0] INIT_LAST  = ICW'((INIT_CYCLES > 0) ? INIT_CYCLES - 1 : 0);
   localparam logic [OW-1:0]  OUTST_MAX  = OW'(MAX_OUTST);
   localparam logic [31:0]    LFSR_TAPS  = 32'h8020_0003;
   localparam logic [DW-1:0]  CB_EVEN    = {DW/2{2'b01}};
   localparam logic [DW-1:0]  CB_ODD     = {DW/2{2'b10}};

   typedef enum logic [2:0] {
      S_INIT,
      S_WRITE,
      S_READ,
      S_DRAIN,
      S_DONE
   } state_t;

   state_t          state, state_n;
   logic [ICW-1:0]  init_cnt;
   logic [AW-1:0]   addr_q;
   logic [1:0]      mode_q;
   logic [AW-1:0]   last_q;
   logic [31:0]     wr_lfsr;
   logic [31:0]     pass_seed;
   logic [AW-1:0]   cmp_addr;
   logic [31:0]     cmp_lfsr;
   logic [OW-1:0]   outst;

   logic            wr_acc;
   logic            rd_acc;
   logic            rsp_ok;
   logic            rsp_dec;
   logic            mismatch;
   logic [DW-1:0]   wr_pat;
   logic [DW-1:0]   exp_pat;

   // 32-bit Galois LFSR, right-shifting, x^32+x^22+x^2+x+1
   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'h0);
   endfunction

   // Data word for address a; parity taken from the pass counter, which is
   // constant for the whole pass, so it is equivalent to a value latched at
   // WRITE entry.
   function automatic logic [DW-1:0] pattern(
      input logic [1:0]    m,
      input logic [AW-1:0] a,
      input logic [31:0]   lf,
      input logic [31:0]   pc
   );
      logic [SW-1:0] sum;
      logic [SW-1:0] sh;
      logic          p;
      logic [DW-1:0] res;
      p   = pc[0];
      sum = SW'(a) + SW'(pc);
      sh  = sum % SW'(DW);
      case (m)
         2'd0:    res = DW'(lf);
         2'd1:    res = DW'(a) ^ {DW{p}};
         2'd2:    res = DW'(1) << sh;
         default: res = (a[0] ^ p) ? CB_ODD : CB_EVEN;
      endcase
      return res;
   endfunction

   assign wr_pat   = pattern(mode_q, addr_q, wr_lfsr, passcount);
   assign exp_pat  = pattern(mode_q, cmp_addr, cmp_lfsr, passcount);
   assign rsp_ok   = rd_valid && ((state == S_READ) || (state == S_DRAIN));
   assign rsp_dec  = rsp_ok && (outst != '0);
   assign mismatch = rsp_ok && (rd_data != exp_pat);

   // Next-state and request-port outputs
   always_comb begin
      state_n   = state;
      req_valid = 1'b0;
      req_we    = 1'b0;
      req_addr  = addr_q;
      req_wdata = '0;
      busy      = 1'b0;
      wr_acc    = 1'b0;
      rd_acc    = 1'b0;
      case (state)
         S_INIT: begin
            if (init_cnt == INIT_LAST) state_n = S_WRITE;
         end
         S_WRITE: begin
            busy      = 1'b1;
            req_valid = 1'b1;
            req_we    = 1'b1;
            req_wdata = wr_pat;
            if (req_ready) begin
               wr_acc = 1'b1;
               if (addr_q == last_q) state_n = S_READ;
            end
         end
         S_READ: begin
            busy      = 1'b1;
            req_valid = (outst != OUTST_MAX);
            if (req_valid && req_ready) begin
               rd_acc = 1'b1;
               if (addr_q == last_q) state_n = S_DRAIN;
            end
         end
         S_DRAIN: begin
            busy = 1'b1;
            if (outst == '0) state_n = S_DONE;
         end
         S_DONE: begin
            state_n = S_WRITE;
         end
         default: state_n = S_INIT;
      endcase
   end

   // State register
   always_ff @(posedge clk) begin
      if (rst) state <= S_INIT;
      else     state <= state_n;
   end

   // Post-reset idle counter
   always_ff @(posedge clk) begin
      if (rst)
         init_cnt <= '0;
      else if ((state == S_INIT) && (init_cnt != INIT_LAST))
         init_cnt <= init_cnt + 1'b1;
   end

   // Request side: pass configuration, address counter, write-side LFSR and
   // pass seed. The write LFSR is never reloaded between passes: at DONE it
   // already holds the state the next pass must start from.
   always_ff @(posedge clk) begin
      if (rst) begin
         addr_q    <= '0;
         mode_q    <= '0;
         last_q    <= '0;
         wr_lfsr   <= SEED;
         pass_seed <= SEED;
      end else begin
         if ((state_n == S_WRITE) && (state != S_WRITE)) begin
            mode_q <= mode;
            last_q <= addr_last;
            addr_q <= '0;
         end
         if (wr_acc) wr_lfsr <= lfsr_step(wr_lfsr);
         if (wr_acc || rd_acc)
            addr_q <= (addr_q == last_q) ? '0 : addr_q + 1'b1;
         if (state == S_DONE) pass_seed <= wr_lfsr;
      end
   end

   // Compare side: regenerates the expected sequence in response order
   always_ff @(posedge clk) begin
      if (rst) begin
         cmp_addr <= '0;
         cmp_lfsr <= SEED;
      end else if ((state == S_WRITE) && (state_n == S_READ)) begin
         cmp_addr <= '0;
         cmp_lfsr <= pass_seed;
      end else if (rsp_ok) begin
         cmp_addr <= cmp_addr + 1'b1;
         cmp_lfsr <= lfsr_step(cmp_lfsr);
      end
   end

   // Reads in flight
   always_ff @(posedge clk) begin
      if (rst)
         outst <= '0;
      else if (rd_acc && !rsp_dec)
         outst <= outst + 1'b1;
      else if (!rd_acc && rsp_dec)
         outst <= outst - 1'b1;
   end

   // Pass/fail statistics and first-error capture
   always_ff @(posedge clk) begin
      if (rst) begin
         passcount      <= '0;
         failcount      <= '0;
         err_flag       <= 1'b0;
         first_err_addr <= '0;
         first_err_exp  <= '0;
         first_err_act  <= '0;
      end else begin
         if ((state == S_DONE) && (passcount != '1))
            passcount <= passcount + 1'b1;
         if (mismatch) begin
            if (failcount != '1) failcount <= failcount + 1'b1;
            if (!err_flag) begin
               err_flag       <= 1'b1;
               first_err_addr <= cmp_addr;
               first_err_exp  <= exp_pat;
               first_err_act  <= rd_data;
            end
         end
      end
   end

endmodule
